cordic_linear_iter: RTL and testbench

Parametrised, iterative linear-mode CORDIC engine on signed fixed-point Q(INT_SIZE.FLOAT_SIZE) operands, one micro-rotation per clock. It computes y + x·z (rotation mode) or z + y/x (vectoring mode) with a configurable iteration count, a busy/done handshake and optional overflow detection. It is the next generation of the team's linear CORDIC unit and sits beside the circular/hyperbolic engines as the multiply/divide primitive of the floating-point datapath.

---
 rtl/cordic_linear_pkg.sv | 25 ++
 rtl/cordic_linear_iter_if.sv | 29 ++
 rtl/cordic_linear_step.sv | 71 +++++++
 rtl/cordic_linear_iter.sv | 132 +++++++++++++
 tb/tb_cordic_linear_iter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_linear_pkg.sv
// Shared definitions for the linear-mode CORDIC engine: mode encodings, FSM state type,
// counter sizing and the per-iteration z increment.
package cordic_linear_pkg;

    localparam logic MODE_ROT = 1'b0;  // y + x*z
    localparam logic MODE_VEC = 1'b1;  // z + y/x

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Counter must hold 0..ITERS inclusive.
    function automatic int unsigned cnt_width(input int unsigned iters);
        return $clog2(iters + 1);
    endfunction

    // ONE >> s, where ONE = 1 << float_size; caller truncates to the datapath width.
    function automatic logic [63:0] one_shr(input int unsigned float_size,
                                            input int unsigned s);
        return (64'd1 << float_size) >> s;
    endfunction

endpackage

// File: rtl/cordic_linear_iter_if.sv
// Operand/result bundle of the linear CORDIC engine. The requester drives the master
// modport, the engine sits on the slave modport.
interface cordic_linear_iter_if #(
    parameter int unsigned W = 32
);

    logic                start;
    logic                mode;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    logic signed [W-1:0] x_out;
    logic signed [W-1:0] y_out;
    logic signed [W-1:0] z_out;
    logic                done;
    logic                busy;
    logic                ovf;

    modport master (
        output start, mode, x, y, z,
        input  x_out, y_out, z_out, done, busy, ovf
    );

    modport slave (
        input  start, mode, x, y, z,
        output x_out, y_out, z_out, done, busy, ovf
    );

endinterface

// File: rtl/cordic_linear_step.sv
// One combinational linear-mode micro-rotation with shift s.
// Optional macro: CORDIC_LINEAR_OVF_EN builds the signed-overflow detectors on the
// y and z adders; otherwise the overflow outputs are constant 0.
module cordic_linear_step
    import cordic_linear_pkg::*;
#(
    parameter int unsigned FLOAT_SIZE = 24,
    parameter int unsigned INT_SIZE   = 8,
    parameter int unsigned SW         = 5,
    localparam int unsigned W         = INT_SIZE + FLOAT_SIZE
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic signed [W-1:0]  z,
    input  logic                 mode,
    input  logic        [SW-1:0] s,
    output logic signed [W-1:0]  y_next,
    output logic signed [W-1:0]  z_next,
    output logic                 y_ovf,
    output logic                 z_ovf
);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] one_sh;
    logic                d_pos;

    assign x_sh   = x >>> s;
    assign one_sh = W'(one_shr(FLOAT_SIZE, 32'(s)));

    // Direction: rotation drives z to 0, vectoring drives y to 0.
    always_comb begin
        d_pos = 1'b0;
        if (mode == MODE_ROT) begin
            d_pos = ~z[W-1];
        end else begin
            d_pos = (y[W-1] != x[W-1]);
        end
    end

    // Micro-rotation adders, wrapping in W bits.
    always_comb begin
        y_next = '0;
        z_next = '0;
        if (d_pos) begin
            y_next = y + x_sh;
            z_next = z - one_sh;
        end else begin
            y_next = y - x_sh;
            z_next = z + one_sh;
        end
    end

`ifdef CORDIC_LINEAR_OVF_EN
    // Overflow when the effective operands share a sign and the result sign differs.
    always_comb begin
        y_ovf = 1'b0;
        z_ovf = 1'b0;
        if (d_pos) begin
            y_ovf = (y[W-1] == x_sh[W-1]) && (y_next[W-1] != y[W-1]);
            z_ovf = (z[W-1] != one_sh[W-1]) && (z_next[W-1] != z[W-1]);
        end else begin
            y_ovf = (y[W-1] != x_sh[W-1]) && (y_next[W-1] != y[W-1]);
            z_ovf = (z[W-1] == one_sh[W-1]) && (z_next[W-1] != z[W-1]);
        end
    end
`else
    assign y_ovf = 1'b0;
    assign z_ovf = 1'b0;
`endif

endmodule

// File: rtl/cordic_linear_iter.sv
// Iterative linear-mode CORDIC engine: one micro-rotation per clock, computing y + x*z
// (rotation) or z + y/x (vectoring) over ITERS cycles with a busy/done handshake.
// Optional macro: CORDIC_LINEAR_OVF_EN enables the sticky overflow flag.
module cordic_linear_iter
    import cordic_linear_pkg::*;
#(
    parameter int unsigned FLOAT_SIZE = 24,
    parameter int unsigned INT_SIZE   = 8,
    parameter int unsigned ITERS      = FLOAT_SIZE
) (
    input logic                 clk,
    input logic                 rst,
    cordic_linear_iter_if.slave bus
);

    localparam int unsigned W  = INT_SIZE + FLOAT_SIZE;
    localparam int unsigned CW = cnt_width(ITERS);

    if (ITERS < 1 || ITERS > FLOAT_SIZE) begin : g_iters_range
        $error("cordic_linear_iter: ITERS must be within 1..FLOAT_SIZE");
    end

    state_e              state_q, state_d;
    logic signed [W-1:0] x_q, y_q, z_q;
    logic signed [W-1:0] y_next, z_next;
    logic                mode_q;
    logic        [CW-1:0] cnt_q;
    logic                y_ovf, z_ovf;
    logic                load, busy, done, iter_last;
    logic                ovf;

    assign iter_last = (cnt_q == CW'(ITERS - 1));

    cordic_linear_step #(
        .FLOAT_SIZE (FLOAT_SIZE),
        .INT_SIZE   (INT_SIZE),
        .SW         (CW)
    ) u_step (
        .x      (x_q),
        .y      (y_q),
        .z      (z_q),
        .mode   (mode_q),
        .s      (cnt_q),
        .y_next (y_next),
        .z_next (z_next),
        .y_ovf  (y_ovf),
        .z_ovf  (z_ovf)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start is only honoured outside RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (bus.start) state_d = StRun;
            StRun:          if (iter_last) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // FSM outputs: handshake levels and operand-load strobe.
    always_comb begin
        load = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StIdle: load = bus.start;
            StRun:  busy = 1'b1;
            StDone: begin
                done = 1'b1;
                load = bus.start;
            end
            default: ;
        endcase
    end

    // Working registers and iteration counter; x is held constant across the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            mode_q <= MODE_ROT;
            cnt_q  <= '0;
        end else if (load) begin
            x_q    <= bus.x;
            y_q    <= bus.y;
            z_q    <= bus.z;
            mode_q <= bus.mode;
            cnt_q  <= '0;
        end else if (busy) begin
            y_q    <= y_next;
            z_q    <= z_next;
            cnt_q  <= cnt_q + CW'(1);
        end
    end

`ifdef CORDIC_LINEAR_OVF_EN
    logic ovf_q;

    // Sticky overflow, cleared when a new operation is accepted.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            ovf_q <= 1'b0;
        end else if (busy && (y_ovf || z_ovf)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = y_ovf ^ z_ovf;
    assign ovf        = 1'b0;
`endif

    assign bus.x_out = x_q;
    assign bus.y_out = y_q;
    assign bus.z_out = z_q;
    assign bus.done  = done;
    assign bus.busy  = busy;
    assign bus.ovf   = ovf;

endmodule

// File: tb/tb_cordic_linear_iter.sv
// Scoreboard bench for cordic_linear_iter (Q8.24, ITERS = 24) plus an ITERS = 1 instance.
module tb_cordic_linear_iter;
    import cordic_linear_pkg::*;

    localparam int unsigned FS    = 24;
    localparam int unsigned IS    = 8;
    localparam int unsigned W     = IS + FS;
    localparam int unsigned ITERS = 24;
    localparam int          TOL   = 64;
`ifdef CORDIC_LINEAR_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        string               name;
        logic signed [W-1:0] ex;
        logic signed [W-1:0] ey;
        logic signed [W-1:0] ez;
        bit                  chk_val;
        bit                  eovf;
        longint              dcyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_pass = 0;
    exp_t   sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_linear_iter_if #(.W(W)) bus ();
    cordic_linear_iter_if #(.W(W)) bus1 ();

    cordic_linear_iter #(
        .FLOAT_SIZE (FS),
        .INT_SIZE   (IS),
        .ITERS      (ITERS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cordic_linear_iter #(
        .FLOAT_SIZE (FS),
        .INT_SIZE   (IS),
        .ITERS      (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input bit ok, input string nm, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, req, req);
    endtask

    task automatic drive(input logic m, input logic signed [W-1:0] xi,
                         input logic signed [W-1:0] yi, input logic signed [W-1:0] zi);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.x     = xi;
        bus.y     = yi;
        bus.z     = zi;
    endtask

    // Called just after an accepting edge: queue the expected response.
    task automatic expect_op(input string nm, input logic signed [W-1:0] xi,
                             input logic signed [W-1:0] ey, input logic signed [W-1:0] ez,
                             input bit cv, input bit eo);
        exp_t e;
        e.name = nm; e.ex = xi; e.ey = ey; e.ez = ez;
        e.chk_val = cv; e.eovf = eo; e.dcyc = cyc + ITERS;
        sb.push_back(e);
    endtask

    // Issue one operation from an idle/done engine (called at a negedge).
    task automatic issue(input string nm, input logic m, input logic signed [W-1:0] xi,
                         input logic signed [W-1:0] yi, input logic signed [W-1:0] zi,
                         input logic signed [W-1:0] ey, input logic signed [W-1:0] ez,
                         input bit cv, input bit eo);
        drive(m, xi, yi, zi);
        @(posedge clk); #1;
        expect_op(nm, xi, ey, ez, cv, eo);
        bus.start = 1'b0;
        chk(bus.done === 1'b0, {nm, " done_fall"}, longint'(bus.done), 0);
        chk(bus.ovf === 1'b0, {nm, " ovf_clear"}, longint'(bus.ovf), 0);
        @(negedge clk);
        chk(bus.busy === 1'b1, {nm, " busy"}, longint'(bus.busy), 1);
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) chk(1'b0, {nm, " timeout"}, 0, 1);
    endtask

    // Monitor: pop and compare on every rising edge of done.
    initial begin : monitor
        bit     dprev;
        exp_t   e;
        longint dy, dz;
        dprev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && bus.done === 1'b1 && !dprev) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "extra_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk(cyc == e.dcyc, {e.name, " latency"}, cyc, e.dcyc);
                    chk(bus.x_out === e.ex, {e.name, " x_out"}, bus.x_out, e.ex);
                    chk(bus.ovf === e.eovf, {e.name, " ovf"}, longint'(bus.ovf), e.eovf);
                    if (e.chk_val) begin
                        dy = longint'(bus.y_out) - longint'(e.ey);
                        dz = longint'(bus.z_out) - longint'(e.ez);
                        chk(dy >= -TOL && dy <= TOL, {e.name, " y_out"}, bus.y_out, e.ey);
                        chk(dz >= -TOL && dz <= TOL, {e.name, " z_out"}, bus.z_out, e.ez);
                    end
                end
            end
            dprev = (bus.done === 1'b1);
        end
    end

    initial begin : stim
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = MODE_ROT; bus.x = '0; bus.y = '0; bus.z = '0;
        bus1.start = 1'b0; bus1.mode = MODE_ROT; bus1.x = '0; bus1.y = '0; bus1.z = '0;
        repeat (2) @(posedge clk);
        #1;
        chk(bus.x_out === '0, "rst x_out", bus.x_out, 0);
        chk(bus.y_out === '0, "rst y_out", bus.y_out, 0);
        chk(bus.z_out === '0, "rst z_out", bus.z_out, 0);
        chk(bus.done === 1'b0, "rst done", longint'(bus.done), 0);
        chk(bus.busy === 1'b0, "rst busy", longint'(bus.busy), 0);
        chk(bus.ovf === 1'b0, "rst ovf", longint'(bus.ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1.5 * 0.5 = 0.75, z -> 0
        issue("rot_a", MODE_ROT, 32'h01800000, 32'h00000000, 32'h00800000,
              32'h00C00000, 32'h00000000, 1'b1, 1'b0);
        wait_done("rot_a");
        // 1.0 / 2.0 = 0.5, y -> 0
        issue("vec_pos", MODE_VEC, 32'h02000000, 32'h01000000, 32'h00000000,
              32'h00000000, 32'h00800000, 1'b1, 1'b0);
        wait_done("vec_pos");
        // 0.75 / -1.0 = -0.75
        issue("vec_neg", MODE_VEC, 32'hFF000000, 32'h00C00000, 32'h00000000,
              32'h00000000, 32'hFF400000, 1'b1, 1'b0);
        wait_done("vec_neg");

        // Back-to-back: start held through RUN with junk operands, then op2 taken in DONE.
        drive(MODE_ROT, 32'h01000000, 32'h00400000, 32'hFF800000);
        @(posedge clk); #1;
        expect_op("b2b_1", 32'h01000000, 32'hFFC00000, 32'h00000000, 1'b1, 1'b0);
        for (int n = 0; n < int'(ITERS); n++) begin
            drive(MODE_VEC, 32'h7FFFFFFF, 32'h12345678, 32'h00C00000);
            @(posedge clk); #1;
        end
        drive(MODE_VEC, 32'h01000000, 32'hFF400000, 32'h00400000);
        @(posedge clk); #1;
        expect_op("b2b_2", 32'h01000000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0);
        bus.start = 1'b0;
        wait_done("b2b_2");

        // Reset at iteration 10 together with start; the operation is discarded.
        @(negedge clk);
        drive(MODE_ROT, 32'h01000000, 32'h00000000, 32'h00400000);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        drive(MODE_ROT, 32'h01000000, 32'h01000000, 32'h01000000);
        rst = 1'b1;
        @(posedge clk); #1;
        chk(bus.x_out === '0, "midrst x_out", bus.x_out, 0);
        chk(bus.y_out === '0, "midrst y_out", bus.y_out, 0);
        chk(bus.z_out === '0, "midrst z_out", bus.z_out, 0);
        chk(bus.done === 1'b0, "midrst done", longint'(bus.done), 0);
        chk(bus.busy === 1'b0, "midrst busy", longint'(bus.busy), 0);
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk(bus.busy === 1'b0, "postrst idle", longint'(bus.busy), 0);
        // -2.0 * 0.75 + 1.0 = -0.5
        issue("after_rst", MODE_ROT, 32'hFE000000, 32'h01000000, 32'h00C00000,
              32'hFF800000, 32'h00000000, 1'b1, 1'b0);
        wait_done("after_rst");

        // 100 * 1.9 leaves the Q8.24 range; only the flag is checked.
        issue("ovf_op", MODE_ROT, 32'h64000000, 32'h00000000, 32'h01E66666,
              32'h00000000, 32'h00000000, 1'b0, OVF_ON);
        wait_done("ovf_op");
        // 0.5 * 1.0 = 0.5; flag must have been cleared by this start
        issue("post_ovf", MODE_ROT, 32'h00800000, 32'h00000000, 32'h01000000,
              32'h00800000, 32'h00000000, 1'b1, 1'b0);
        wait_done("post_ovf");

        // ITERS = 1: y = 0 + 1.0 (d=+1), z = 0.25 - 1.0 = -0.75
        @(negedge clk);
        bus1.start = 1'b1; bus1.mode = MODE_ROT;
        bus1.x = 32'h01000000; bus1.y = 32'h00000000; bus1.z = 32'h00400000;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        chk(bus1.busy === 1'b1, "it1 busy", longint'(bus1.busy), 1);
        chk(bus1.done === 1'b0, "it1 not_done", longint'(bus1.done), 0);
        @(posedge clk); #1;
        chk(bus1.done === 1'b1, "it1 done", longint'(bus1.done), 1);
        chk(bus1.busy === 1'b0, "it1 busy_low", longint'(bus1.busy), 0);
        chk(bus1.y_out === 32'sh01000000, "it1 y_out", bus1.y_out, 32'sh01000000);
        chk(bus1.z_out === 32'shFF400000, "it1 z_out", bus1.z_out, 32'shFF400000);
        chk(bus1.x_out === 32'sh01000000, "it1 x_out", bus1.x_out, 32'sh01000000);

        repeat (30) @(negedge clk);
        chk(sb.size() == 0, "sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
